// File: rtl/dff_gates_sched.sv
// rtl/dff_gates_sched.sv - round-robin scheduler sharing one serial x/z datapath between NREQ requesters
//
// Purpose: accepts WIDTH-bit jobs from NREQ requesters (strict round-robin),
// clears the datapath, shifts the word into x LSB-first, gathers z after every
// bit and returns the result word tagged with the requester index.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   [NREQ]        per-requester job valid
//   req_data   in   [NREQ*WIDTH]  job words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  [NREQ]        one-hot accept pulse (combinational)
//   dp_x       out  serial bit to the datapath, registered
//   dp_rst_n   out  datapath reset, active-low, registered
//   dp_z       in   datapath output
//   rsp_valid  out  result available
//   rsp_data   out  [WIDTH] result word
//   rsp_id     out  [IDW]   owner of the result
//   rsp_ready  in   result consumer accepts
//   job_count  out  [16]    completed-job counter (only with DFF_SCHED_COUNT_EN)
//
// Optional feature macro: DFF_SCHED_COUNT_EN

module dff_gates_sched #(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  dp_x,
  output logic                  dp_rst_n,
  input  logic                  dp_z,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
`ifdef DFF_SCHED_COUNT_EN
  ,
  output logic [15:0]           job_count
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_bit;
  logic             r_dp_x;
  logic             r_dp_rst_n;
  logic             r_rsp_valid;

  logic             w_hi_found;
  logic [IDW-1:0]   w_hi_idx;
  logic             w_any;
  logic [IDW-1:0]   w_lo_idx;
  logic [IDW-1:0]   w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_accept;
  logic [WIDTH-1:0] w_word_sh;
  logic [WIDTH-1:0] w_res_sh;
  logic             w_last_bit;

  // Round-robin: lowest valid index above r_last wins; otherwise wrap to the
  // lowest valid index overall. Descending loop leaves the lowest match.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_any      = 1'b0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_any    = 1'b1;
        w_lo_idx = IDW'(i);
        if (IDW'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDW'(i);
        end
      end
    end
    w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Held low while rst is asserted so no accept pulse can appear in reset.
  always_comb begin
    w_accept   = (r_state == S_IDLE) && w_any && rst;
    w_gnt_data = '0;
    req_ready  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_gnt_idx) begin
        w_gnt_data   = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = w_accept;
      end
    end
  end

  // Word shifts right so the next bit is always at [0]; z samples enter at
  // the MSB and after WIDTH samples the first one lands in bit 0.
  assign w_word_sh  = r_word >> 1;
  assign w_res_sh   = WIDTH'({dp_z, r_res} >> 1);
  assign w_last_bit = (r_bit == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_word      <= '0;
      r_res       <= '0;
      r_bit       <= '0;
      r_dp_x      <= 1'b0;
      r_dp_rst_n  <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last     <= w_gnt_idx;
            r_id       <= w_gnt_idx;
            r_word     <= w_gnt_data;
            r_res      <= '0;
            r_bit      <= '0;
            r_dp_rst_n <= 1'b1;
            r_dp_x     <= w_gnt_data[0];
          end
        end
        S_SHIFT: begin
          // z during SHIFT cycle 0 still reflects the cleared cell.
          if (r_bit != '0) r_res <= w_res_sh;
          r_word <= w_word_sh;
          r_bit  <= r_bit + 1'b1;
          r_dp_x <= w_last_bit ? 1'b0 : w_word_sh[0];
        end
        S_DRAIN: begin
          r_res       <= w_res_sh;
          r_dp_rst_n  <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        S_DONE: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DFF_SCHED_COUNT_EN
  logic [15:0] r_job_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_job_cnt <= '0;
    else if (r_rsp_valid && rsp_ready) r_job_cnt <= r_job_cnt + 16'd1;
  end

  assign job_count = r_job_cnt;
`endif

  assign dp_x      = r_dp_x;
  assign dp_rst_n  = r_dp_rst_n;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_res;
  assign rsp_id    = r_id;

endmodule

// File: doc/dff_gates_sched.md
# dff_gates_sched

Round-robin scheduler that shares one gated-flop datapath (x/z serial cell with active-low async reset) between NREQ requesters. Each requester hands over a WIDTH-bit word via valid/ready. The scheduler clears the datapath, shifts the word into `x` LSB-first, collects `z` after every bit into a result word, and returns it on a response handshake tagged with the requester index. It sits between the requester logic and the single datapath instance.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `WIDTH`, 8: job word width, 1..32.
- `IDW`, `$clog2(NREQ)`, local: width of the requester index.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester job valid.
- `req_data`  in  NREQ*WIDTH  job words; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  one-hot accept pulse.
- `dp_x`  out  1  serial bit to the datapath `x`, registered.
- `dp_rst_n`  out  1  datapath reset, active-low, registered, glitch-free.
- `dp_z`  in  1  datapath `z`.
- `rsp_valid`  out  1  result available.
- `rsp_data`  out  WIDTH  result word; bit k = `z` after bits 0..k were consumed.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_ready`  in  1  result consumer accepts.

## Operation
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE: `dp_rst_n`=0, `dp_x`=0. If any `req_valid` is high, grant the first requester at or after `last+1` (mod NREQ). Drive `req_ready[g]`=1 combinationally for that one cycle. Latch `req_data[g]`, latch `g`, set `last`=g, bit index=0, go to SHIFT. If no request is pending, stay in IDLE.
- SHIFT, WIDTH cycles, k=0..WIDTH-1: `dp_rst_n`=1, `dp_x`=word[k]. From the second SHIFT cycle on, sample `dp_z` into result bit k-1 on each edge. After cycle WIDTH-1, go to DRAIN.
- DRAIN, 1 cycle: `dp_rst_n`=1, `dp_x`=0. Sample `dp_z` into result bit WIDTH-1, then go to DONE.
- DONE: `rsp_valid`=1, with `rsp_data` and `rsp_id` held stable. `dp_rst_n`=0 and `dp_x`=0. On `rsp_valid && rsp_ready`, go to IDLE.
- Requests are never accepted in DONE or in the cycle the response is accepted. Acceptance is earliest in the following IDLE cycle, so the datapath always sees at least 2 reset cycles between jobs.
- `req_valid` may drop before a grant with no effect. Requesters hold `req_data` stable while valid.
- Round-robin is strict. A requester that holds `req_valid` continuously gets a grant within NREQ jobs.
- Reset values: state=IDLE, `last`=NREQ-1 (requester 0 wins first), `req_ready`=0, `dp_x`=0, `dp_rst_n`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
- Reset mid-job: `dp_rst_n` goes to 0 asynchronously with `rst`. The job is discarded and no response is produced.

## Timing
- Accept edge E0 starts SHIFT. `dp_rst_n` rises at E0; the first datapath clock edge with reset released is E0+1 cycle, which gives one full cycle of recovery.
- `rsp_valid` rises at edge E0+WIDTH+1.
- Minimum job period with `rsp_ready` tied high: WIDTH+3 cycles.
- `req_ready` is the only combinational output. All datapath-facing outputs come directly from flops.

## Configuration
- `DFF_SCHED_COUNT_EN` defined: adds output `job_count` (16 bits, reset 0).
  - Increments by 1 on each `rsp_valid && rsp_ready` handshake.
  - Wraps from 0xFFFF to 0.
  - Is reset asynchronously with `rst`.
- Undefined: no `job_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then requester 0 sends 0x00 (WIDTH=8) -> `req_ready[0]` pulses once, `dp_x` stays 0 for 8 cycles, `rsp_valid` rises 9 cycles after accept with `rsp_data`=0xAA and `rsp_id`=0.
- Requester 1 sends 0xFF -> `rsp_data`=0x00, `rsp_id`=1; `dp_rst_n` is high exactly 9 cycles.
- Both requesters hold `req_valid` with `rsp_ready`=1 for 4 jobs -> grant order 0,1,0,1, each `req_ready` a single-cycle one-hot pulse, job period 11 cycles.
- Hold `rsp_ready`=0 for 5 cycles in DONE while both requests are pending -> `rsp_valid`, `rsp_data` and `rsp_id` stay stable, no `req_ready`, `dp_rst_n`=0; the next accept occurs 1 cycle after the response handshake.
- Assert `rst` during SHIFT cycle 3 -> `dp_rst_n`=0 and `rsp_valid`=0 immediately, no response for that job. After release, requester 0 has priority.
- With `DFF_SCHED_COUNT_EN`: preload the count via 65535 handshakes (or force it), then 1 more handshake -> `job_count` wraps to 0.
